main_mem_block_responder: RTL
=============================

// Module: main_mem_block_responder
// PURPOSE
//  Responder end of the data-cache <-> main-memory block interface (MAIN_MEM_* signals).
//  Serves 128-bit block reads and writes from a fixed-latency storage array.
//  Holds busywait high while an access is in flight.
//  Sits below data_cache_memory in the MA stage; the cache is the sole initiator.
// PARAMETERS
//  ADDR_WIDTH   28   block address width (byte address >> 4)
//  DATA_WIDTH   128  block width in bits
//  INDEX_WIDTH  8    storage index bits; DEPTH = 2**INDEX_WIDTH blocks
//  LATENCY      5    clock edges from request capture to completion; legal range 1..255
// PORTS
//  clock      in   1            single clock, rising edge
//  reset      in   1            asynchronous, active-low
//  read       in   1            block read request; held by initiator until busywait low
//  write      in   1            block write request; held by initiator until busywait low
//  address    in   ADDR_WIDTH   block address
//  writedata  in   DATA_WIDTH   block to store
//  readdata   out  DATA_WIDTH   block returned by last completed read
//  busywait   out  1            access in flight; initiator must stall
// BEHAVIOUR
//  Reset (reset==0, async)
//   - state=IDLE; counter=0; readdata=0; busywait forced 0; all DEPTH blocks cleared to 0.
//   - Reset mid-access aborts the access; an aborted write is never committed.
//  FSM states
//   IDLE:   if (read|write) at posedge -> latch op, address[INDEX_WIDTH-1:0], writedata;
//           counter=LATENCY-1; go ACCESS.
//   ACCESS: at posedge with counter!=0 -> counter-1.
//           At posedge with counter==0 -> commit write, or load readdata from array; go DONE.
//   DONE:   ignore request inputs for exactly one posedge; go IDLE.
//           DONE absorbs the still-held old request before the initiator drops it.
//  busywait (combinational)
//   - busywait = (state==ACCESS) | (state==IDLE & (read|write)).
//   - Rises in the same cycle a request appears; no false-completion window.
//   - Low in DONE.
//  Latency
//   - Request captured at edge Es; completion at edge Es+LATENCY; busywait low after that edge.
//   - LATENCY=1 -> complete on the edge after capture.
//  Data rules
//   - Index uses address[INDEX_WIDTH-1:0]; upper address bits are ignored (aliasing wraps).
//   - readdata changes only on read completion or reset; a write leaves readdata unchanged.
//   - Inputs changing during ACCESS have no effect (latched copy used).
//  Boundary cases
//   - read & write both high at capture: write wins; readdata unchanged.
//   - Back-to-back requests (write-back then fill): new request seen in IDLE the cycle after DONE.
//     busywait rises immediately.
// STRUCTURE
//  - mem_defs.vh (shared include): state encodings IDLE/ACCESS/DONE (2-bit) and OP_READ/OP_WRITE.
//    Also holds default widths, shared with data_cache_memory.
//  - Sub-module mem_block_array: DEPTH x DATA_WIDTH storage.
//    1 sync write port, 1 sync read port, async active-low clear.
//  - Top level: FSM, latency counter, request latches, busywait logic.
// TESTING
//  1. Reset, then read addr 28'h0000010
//     -> busywait high same cycle, low after exactly 5 edges; readdata==128'h0.
//  2. Write 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF to 28'h0000010, then read it back
//     -> match; readdata unchanged after the write.
//  3. Write 28'h0000002, then immediately read 28'h0000010 (held request through DONE)
//     -> exactly two accesses, 5 edges each; no extra or re-triggered access.
//  4. Write to 28'h0000105 with INDEX_WIDTH=8, then read 28'h0000005 -> aliased data returned.
//  5. Assert reset low 2 edges into a write to 28'h0000030, then read 28'h0000030
//     -> busywait drops immediately on reset; read returns 0.
//  6. read=write=1 with writedata 128'h1 at 28'h0000007; read 28'h0000007 -> 128'h1.
//     LATENCY=1 variant: completion on the edge after capture.

Source files
------------

// File: rtl/main_mem_block_responder_pkg.sv
// Shared definitions for the main-memory block responder: default widths,
// FSM state encoding and operation encoding.
package main_mem_block_responder_pkg;

    localparam int DEF_ADDR_WIDTH  = 28;
    localparam int DEF_DATA_WIDTH  = 128;
    localparam int DEF_INDEX_WIDTH = 8;
    localparam int DEF_LATENCY     = 5;

    // Wide enough for LATENCY-1 with LATENCY up to 255
    localparam int CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // A simultaneous read and write resolves to a write
    function automatic op_t decode_op(input logic rd, input logic wr);
        return wr ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/main_mem_block_responder_mem_block_array.sv
// DEPTH x DATA_WIDTH block storage with one synchronous write port, one
// synchronous read port and an asynchronous active-low clear of every block
// and of the read register.
module mem_block_array #(
    parameter int DATA_WIDTH  = 128,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   re,
    input  logic [INDEX_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [DEPTH-1:0]      row_we;

    // One-hot row write enables decoded from the write index
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row_we
            assign row_we[gi] = we && (waddr == INDEX_WIDTH'(gi));
        end
    endgenerate

    // Storage rows: cleared as a whole on reset, written one row at a time
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (row_we[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
        end
    end

    // Registered read: holds its value until the next read strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/main_mem_block_responder.sv
// Responder end of the data-cache <-> main-memory block interface. Captures a
// read or write request, waits a fixed number of clock edges, then commits
// the write or returns the block. busywait stalls the initiator meanwhile.
module main_mem_block_responder
    import main_mem_block_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  busywait
);

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   count_reg;
    op_t                    op_reg;
    logic [INDEX_WIDTH-1:0] index_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;

    logic request;
    logic capture;
    logic mem_we;
    logic mem_re;

    // Upper address bits select nothing: blocks alias modulo DEPTH
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[ADDR_WIDTH-1:INDEX_WIDTH];

    assign request = read | write;
    assign capture = (state_reg == IDLE) && request;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: DONE always lasts one edge so a still-held request
    // from the finished access is not mistaken for a new one
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (request) state_next = ACCESS;
            ACCESS:  if (count_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: busywait rises combinationally with the request, is forced low
    // while reset is asserted, and is low in DONE
    always_comb begin
        busywait = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        case (state_reg)
            IDLE: begin
                busywait = reset && request;
            end
            ACCESS: begin
                busywait = reset;
                if (count_reg == '0) begin
                    mem_we = (op_reg == OP_WRITE);
                    mem_re = (op_reg == OP_READ);
                end
            end
            default: begin
                busywait = 1'b0;
            end
        endcase
    end

    // Request latches and latency counter; inputs are ignored after capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_reg    <= OP_READ;
            index_reg <= '0;
            wdata_reg <= '0;
            count_reg <= '0;
        end else if (capture) begin
            op_reg    <= decode_op(read, write);
            index_reg <= address[INDEX_WIDTH-1:0];
            wdata_reg <= writedata;
            count_reg <= CNT_WIDTH'(LATENCY - 1);
        end else if ((state_reg == ACCESS) && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    mem_block_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .waddr (index_reg),
        .wdata (wdata_reg),
        .re    (mem_re),
        .raddr (index_reg),
        .rdata (readdata)
    );

endmodule
